aes256_sbox_arbiter: RTL and testbench
======================================

// Module: aes256_sbox_arbiter
// PURPOSE
// - Shares one combinational aes256_subbytes instance between two requesters:
//   the round datapath (128-bit SubBytes/InvSubBytes) and key expansion (32-bit SubWord).
// - Arbitrates between them, registers the operand, drives the shared S-box,
//   and returns a registered result to the winning requester.
// - Sits between the round controller, the key scheduler and a single S-box
//   bank, so the design needs only one S-box/inverse-S-box pair.
// PARAMETERS
// - ARB_MODE   1   0 = fixed priority (key expansion always wins); 1 = round-robin
// PORTS
// - clk_i       in   1    clock
// - rst_i       in   1    synchronous reset, active-high
// - st_req_i    in   1    round datapath request; held with operands stable until st_ack_o
// - st_mode_i   in   1    0 = SubBytes (SBOX), 1 = InvSubBytes (INV_SBOX)
// - st_data_i   in   128  state operand, FIPS-197 order (byte0 = [127:120])
// - st_ack_o    out  1    1-cycle pulse: state operand accepted
// - st_vld_o    out  1    1-cycle pulse: st_data_o valid
// - st_data_o   out  128  substituted state
// - kw_req_i    in   1    key-expansion request; held with operand stable until kw_ack_o
// - kw_data_i   in   32   word operand for SubWord (forward S-box only)
// - kw_ack_o    out  1    1-cycle pulse: word accepted
// - kw_vld_o    out  1    1-cycle pulse: kw_data_o valid
// - kw_data_o   out  32   SubWord result
// - sb_mode_o   out  1    to the shared S-box mode_i
// - sb_state_o  out  128  to the shared S-box state_i
// - sb_state_i  in   128  from the shared S-box state_o (combinational)
// - busy_o      out  1    1 while in LOOKUP or RESP
// BEHAVIOUR
// - FSM states: IDLE, LOOKUP, RESP. On reset: state = IDLE; all outputs = 0;
//   last_owner = ST, so the first round-robin tie goes to KW.
// - IDLE/RESP, any request pending:
//   - Arbitrate and pulse the winner's ack_o (combinational from state and requests).
//   - Latch the operand into op_reg, the mode into mode_reg, and the owner.
//   - Next state is LOOKUP.
// - IDLE with no request: stay in IDLE. RESP with no request: go to IDLE.
// - Arbitration when both requests are high:
//   - ARB_MODE = 0: KW wins.
//   - ARB_MODE = 1: the requester not equal to last_owner wins.
//   - last_owner updates on every accept.
// - Single requester: that requester wins, regardless of ARB_MODE.
// - Operand packing:
//   - ST: sb_state_o = st operand; sb_mode_o = st_mode_i.
//   - KW: sb_state_o = {96'h0, kw operand}; sb_mode_o = 0, forced regardless of any input.
// - LOOKUP: drive sb_state_o/sb_mode_o from the registers.
//   - At the clock edge, capture sb_state_i into res_reg and go to RESP.
//   - ST result: full 128 bits. KW result: bits [31:0].
// - RESP: pulse the owner's vld_o. Output data = res_reg.
//   - st_data_o/kw_data_o hold the last result until the next capture.
// - Outside LOOKUP: sb_state_o = 0, sb_mode_o = 0. All results are registered.
// - Latency: accept on cycle N, vld on cycle N+2.
//   Throughput: one operation per 2 cycles (accept may coincide with RESP).
// - Only one operation is ever in flight. ack and vld for the same requester
//   never occur in the same cycle for the same operation.
// - A request withdrawn before ack is dropped silently; no state change.
// - rst_i asserted mid-operation aborts the operation: no vld, FSM returns to IDLE.
// TESTING
// - ST only, st_mode_i = 0, st_data_i = 128'h0:
//   -> st_ack_o at N, st_vld_o at N+2, st_data_o = {16{8'h63}}.
// - ST decrypt, st_mode_i = 1, st_data_i = {16{8'h63}}:
//   -> st_data_o = 128'h0. Input byte 8'hED -> output byte 8'h53.
// - KW only, kw_data_i = 32'h00010203:
//   -> kw_vld_o at N+2, kw_data_o = 32'h637C777B, sb_mode_o = 0 in LOOKUP.
// - Both requesting continuously, ARB_MODE = 1:
//   -> acks alternate KW, ST, KW, ST on cycles 0, 2, 4, 6; results match the S-box.
// - ARB_MODE = 0, both requesting:
//   -> KW acked every 2 cycles, ST never acked until kw_req_i drops, then ST is served.
// - rst_i pulsed in LOOKUP: no vld pulse, busy_o = 0 the next cycle,
//   and a fresh request completes normally.

Source files
------------

// File: rtl/aes256_sbox_arbiter.sv
// rtl/aes256_sbox_arbiter.sv - shares one SubBytes/InvSubBytes S-box bank between the
// round datapath (128-bit state) and key expansion (32-bit SubWord), one operation in flight.
module aes256_sbox_arbiter #(
  parameter int ARB_MODE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         st_req_i,
  input  logic         st_mode_i,
  input  logic [127:0] st_data_i,
  output logic         st_ack_o,
  output logic         st_vld_o,
  output logic [127:0] st_data_o,
  input  logic         kw_req_i,
  input  logic [31:0]  kw_data_i,
  output logic         kw_ack_o,
  output logic         kw_vld_o,
  output logic [31:0]  kw_data_o,
  output logic         sb_mode_o,
  output logic [127:0] sb_state_o,
  input  logic [127:0] sb_state_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t       state;
  logic [127:0] op_reg;
  logic         mode_reg;
  logic         owner_kw;
  logic         last_kw;
  logic         can_accept;
  logic         grant_kw;
  logic         grant_st;

  // A new operation may be accepted while the previous result is being returned.
  always_comb begin
    can_accept = !rst_i && (state == IDLE || state == RESP);
    if (st_req_i && kw_req_i) begin
      grant_kw = (ARB_MODE == 0) ? 1'b1 : !last_kw;
    end else begin
      grant_kw = kw_req_i;
    end
    grant_st = st_req_i && !grant_kw;
  end

  assign st_ack_o   = can_accept && grant_st;
  assign kw_ack_o   = can_accept && grant_kw;
  assign sb_state_o = (state == LOOKUP) ? op_reg : 128'h0;
  assign sb_mode_o  = (state == LOOKUP) && mode_reg;
  assign busy_o     = (state == LOOKUP) || (state == RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      op_reg    <= 128'h0;
      mode_reg  <= 1'b0;
      owner_kw  <= 1'b0;
      last_kw   <= 1'b0;
      st_vld_o  <= 1'b0;
      kw_vld_o  <= 1'b0;
      st_data_o <= 128'h0;
      kw_data_o <= 32'h0;
    end else begin
      st_vld_o <= 1'b0;
      kw_vld_o <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (st_ack_o || kw_ack_o) begin
            state    <= LOOKUP;
            owner_kw <= kw_ack_o;
            last_kw  <= kw_ack_o;
            // SubWord only ever uses the forward S-box.
            if (kw_ack_o) begin
              op_reg   <= {96'h0, kw_data_i};
              mode_reg <= 1'b0;
            end else begin
              op_reg   <= st_data_i;
              mode_reg <= st_mode_i;
            end
          end else begin
            state <= IDLE;
          end
        end
        LOOKUP: begin
          state <= RESP;
          if (owner_kw) begin
            kw_data_o <= sb_state_i[31:0];
            kw_vld_o  <= 1'b1;
          end else begin
            st_data_o <= sb_state_i;
            st_vld_o  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_sbox_arbiter.sv
// tb/tb_aes256_sbox_arbiter.sv - directed bench for aes256_sbox_arbiter with a behavioural
// S-box bank behind each instance (round-robin and fixed-priority).
module tb_aes256_sbox_arbiter;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] fwd(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] inv(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h0;
    for (int i = 0; i < 256; i++) begin
      if (fwd(i[7:0]) == b) r = i[7:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] sub128(input logic mode, input logic [127:0] d);
    logic [127:0] r;
    r = 128'h0;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8*i -: 8] = mode ? inv(d[127 - 8*i -: 8]) : fwd(d[127 - 8*i -: 8]);
    end
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic st_req = 1'b0, st_mode = 1'b0, kw_req = 1'b0;
  logic [127:0] st_din = 128'h0;
  logic [31:0]  kw_din = 32'h0;
  logic st_ack, st_vld, kw_ack, kw_vld, sb_mode, busy;
  logic [127:0] st_dout, sb_out, sb_in;
  logic [31:0]  kw_dout;

  logic st_req_f = 1'b0, st_mode_f = 1'b0, kw_req_f = 1'b0;
  logic [127:0] st_din_f = 128'h0;
  logic [31:0]  kw_din_f = 32'h0;
  logic st_ack_f, st_vld_f, kw_ack_f, kw_vld_f, sb_mode_f, busy_f;
  logic [127:0] st_dout_f, sb_out_f, sb_in_f;
  logic [31:0]  kw_dout_f;

  always_comb sb_in = sub128(sb_mode, sb_out);
  always_comb sb_in_f = sub128(sb_mode_f, sb_out_f);

  aes256_sbox_arbiter #(.ARB_MODE(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .st_req_i(st_req), .st_mode_i(st_mode), .st_data_i(st_din),
    .st_ack_o(st_ack), .st_vld_o(st_vld), .st_data_o(st_dout),
    .kw_req_i(kw_req), .kw_data_i(kw_din),
    .kw_ack_o(kw_ack), .kw_vld_o(kw_vld), .kw_data_o(kw_dout),
    .sb_mode_o(sb_mode), .sb_state_o(sb_out), .sb_state_i(sb_in), .busy_o(busy));

  aes256_sbox_arbiter #(.ARB_MODE(0)) dut_f (
    .clk_i(clk), .rst_i(rst),
    .st_req_i(st_req_f), .st_mode_i(st_mode_f), .st_data_i(st_din_f),
    .st_ack_o(st_ack_f), .st_vld_o(st_vld_f), .st_data_o(st_dout_f),
    .kw_req_i(kw_req_f), .kw_data_i(kw_din_f),
    .kw_ack_o(kw_ack_f), .kw_vld_o(kw_vld_f), .kw_data_o(kw_dout_f),
    .sb_mode_o(sb_mode_f), .sb_state_o(sb_out_f), .sb_state_i(sb_in_f), .busy_o(busy_f));

  int checks = 0;
  int failures = 0;

  task automatic test_reset;
    st_req = 1'b1; kw_req = 1'b1; st_req_f = 1'b1; kw_req_f = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({st_ack, kw_ack, st_vld, kw_vld, busy, sb_mode} !== 6'b0 || sb_out !== 128'h0 ||
        st_dout !== 128'h0 || kw_dout !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs ctl=%b sb=%h st=%h kw=%h expected all zero",
               {st_ack, kw_ack, st_vld, kw_vld, busy, sb_mode}, sb_out, st_dout, kw_dout);
    end
    checks++;
    if ({st_ack_f, kw_ack_f, st_vld_f, kw_vld_f, busy_f} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs_fixed ctl=%b expected 00000",
               {st_ack_f, kw_ack_f, st_vld_f, kw_vld_f, busy_f});
    end
    @(negedge clk);
    rst = 1'b0; st_req = 1'b0; kw_req = 1'b0; st_req_f = 1'b0; kw_req_f = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || st_ack !== 1'b0 || kw_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b st_ack=%b kw_ack=%b expected 0 0 0", busy, st_ack, kw_ack);
    end
  endtask

  task automatic run_st(input logic mode, input logic [127:0] data, input logic [127:0] expv,
                        input string name);
    @(negedge clk);
    st_req = 1'b1; st_mode = mode; st_din = data; #1;
    checks++;
    if (st_ack !== 1'b1 || kw_ack !== 1'b0) begin
      failures++;
      $display("FAIL %s_ack st_ack=%b kw_ack=%b expected 1 0", name, st_ack, kw_ack);
    end
    @(negedge clk);
    st_req = 1'b0; #1;
    checks++;
    if (busy !== 1'b1 || sb_out !== data || sb_mode !== mode || st_vld !== 1'b0) begin
      failures++;
      $display("FAIL %s_lookup busy=%b sb_state=%h sb_mode=%b vld=%b expected 1 %h %b 0",
               name, busy, sb_out, sb_mode, st_vld, data, mode);
    end
    @(negedge clk); #1;
    checks++;
    if (st_vld !== 1'b1 || kw_vld !== 1'b0 || st_dout !== expv) begin
      failures++;
      $display("FAIL %s_result st_vld=%b kw_vld=%b data=%h expected 1 0 %h",
               name, st_vld, kw_vld, st_dout, expv);
    end
    @(negedge clk); #1;
    checks++;
    if (st_vld !== 1'b0 || busy !== 1'b0 || sb_out !== 128'h0 || sb_mode !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle vld=%b busy=%b sb_state=%h sb_mode=%b expected 0 0 0 0",
               name, st_vld, busy, sb_out, sb_mode);
    end
  endtask

  task automatic run_kw(input logic [31:0] data, input logic [31:0] expv, input string name);
    @(negedge clk);
    kw_req = 1'b1; kw_din = data; st_mode = 1'b1; #1;
    checks++;
    if (kw_ack !== 1'b1 || st_ack !== 1'b0) begin
      failures++;
      $display("FAIL %s_ack kw_ack=%b st_ack=%b expected 1 0", name, kw_ack, st_ack);
    end
    @(negedge clk);
    kw_req = 1'b0; #1;
    checks++;
    if (sb_mode !== 1'b0 || sb_out !== {96'h0, data} || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_lookup sb_mode=%b sb_state=%h busy=%b expected 0 %h 1",
               name, sb_mode, sb_out, busy, {96'h0, data});
    end
    @(negedge clk); #1;
    checks++;
    if (kw_vld !== 1'b1 || st_vld !== 1'b0 || kw_dout !== expv) begin
      failures++;
      $display("FAIL %s_result kw_vld=%b st_vld=%b data=%h expected 1 0 %h",
               name, kw_vld, st_vld, kw_dout, expv);
    end
    @(negedge clk); #1;
    checks++;
    if (kw_vld !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle kw_vld=%b busy=%b expected 0 0", name, kw_vld, busy);
    end
    st_mode = 1'b0;
  endtask

  task automatic test_round_robin;
    logic ek_ack, es_ack, ek_vld, es_vld;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; st_req = 1'b1; kw_req = 1'b1; st_mode = 1'b0;
    st_din = 128'h0; kw_din = 32'h00010203;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      ek_ack = (c % 4 == 0);
      es_ack = (c % 4 == 2);
      ek_vld = (c >= 2) && (c % 4 == 2);
      es_vld = (c >= 4) && (c % 4 == 0);
      checks++;
      if ({kw_ack, st_ack, kw_vld, st_vld} !== {ek_ack, es_ack, ek_vld, es_vld}) begin
        failures++;
        $display("FAIL rr_cycle%0d kw_ack,st_ack,kw_vld,st_vld=%b expected %b", c,
                 {kw_ack, st_ack, kw_vld, st_vld}, {ek_ack, es_ack, ek_vld, es_vld});
      end
      if (ek_vld) begin
        checks++;
        if (kw_dout !== 32'h637C777B) begin
          failures++;
          $display("FAIL rr_kw_data%0d got=%h expected 637c777b", c, kw_dout);
        end
      end
      if (es_vld) begin
        checks++;
        if (st_dout !== {16{8'h63}}) begin
          failures++;
          $display("FAIL rr_st_data%0d got=%h expected %h", c, st_dout, {16{8'h63}});
        end
      end
    end
    st_req = 1'b0; kw_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (st_vld !== 1'b1 || st_dout !== {16{8'h63}} || kw_ack !== 1'b0 || st_ack !== 1'b0) begin
      failures++;
      $display("FAIL rr_last st_vld=%b data=%h acks=%b%b expected 1 %h 00",
               st_vld, st_dout, kw_ack, st_ack, {16{8'h63}});
    end
    @(negedge clk);
  endtask

  task automatic test_fixed_priority;
    @(negedge clk);
    st_req_f = 1'b1; kw_req_f = 1'b1; st_mode_f = 1'b0;
    st_din_f = 128'h0; kw_din_f = 32'h00010203;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (kw_ack_f !== (c % 2 == 0) || st_ack_f !== 1'b0) begin
        failures++;
        $display("FAIL fixed_cycle%0d kw_ack=%b st_ack=%b expected %b 0",
                 c, kw_ack_f, st_ack_f, (c % 2 == 0));
      end
    end
    @(negedge clk);
    kw_req_f = 1'b0; #1;
    checks++;
    if (st_ack_f !== 1'b1 || kw_ack_f !== 1'b0 || kw_vld_f !== 1'b1 || kw_dout_f !== 32'h637C777B) begin
      failures++;
      $display("FAIL fixed_st_served st_ack=%b kw_ack=%b kw_vld=%b kw_data=%h expected 1 0 1 637c777b",
               st_ack_f, kw_ack_f, kw_vld_f, kw_dout_f);
    end
    @(negedge clk);
    st_req_f = 1'b0; #1;
    checks++;
    if (busy_f !== 1'b1 || st_ack_f !== 1'b0 || st_vld_f !== 1'b0) begin
      failures++;
      $display("FAIL fixed_lookup busy=%b st_ack=%b st_vld=%b expected 1 0 0", busy_f, st_ack_f, st_vld_f);
    end
    @(negedge clk); #1;
    checks++;
    if (st_vld_f !== 1'b1 || st_dout_f !== {16{8'h63}}) begin
      failures++;
      $display("FAIL fixed_st_result vld=%b data=%h expected 1 %h", st_vld_f, st_dout_f, {16{8'h63}});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    st_req = 1'b1; st_mode = 1'b0; st_din = 128'h0; #1;
    checks++;
    if (st_ack !== 1'b1) begin
      failures++;
      $display("FAIL abort_ack st_ack=%b expected 1", st_ack);
    end
    @(negedge clk);
    st_req = 1'b0; rst = 1'b1; #1;
    checks++;
    if (busy !== 1'b1 || st_ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_lookup busy=%b st_ack=%b expected 1 0", busy, st_ack);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || st_vld !== 1'b0 || kw_vld !== 1'b0) begin
      failures++;
      $display("FAIL abort_after busy=%b st_vld=%b kw_vld=%b expected 0 0 0", busy, st_vld, kw_vld);
    end
    @(negedge clk); #1;
    checks++;
    if (st_vld !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_novld st_vld=%b busy=%b expected 0 0", st_vld, busy);
    end
    run_kw(32'h00010203, 32'h637C777B, "abort_fresh");
  endtask

  initial begin
    test_reset();
    run_st(1'b0, 128'h0, {16{8'h63}}, "st_enc");
    run_st(1'b1, {16{8'h63}}, 128'h0, "st_dec");
    run_st(1'b1, {8'hED, {15{8'h63}}}, {8'h53, 120'h0}, "st_dec_ed");
    run_kw(32'h00010203, 32'h637C777B, "kw");
    test_round_robin();
    test_fixed_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
